serial_shift_scheduler: RTL and testbench

//   Shares one LSB-first bit serializer among NUM_REQ requesters. Round-robin arbiter

---
 rtl/serial_shift_scheduler_pkg.sv | 32 +++
 rtl/serial_shift_scheduler_if.sv | 36 +++
 rtl/serial_shift_scheduler_arb.sv | 31 +++
 rtl/serial_shift_scheduler.sv | 104 ++++++++++
 tb/tb_serial_shift_scheduler.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/serial_shift_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Module : ser_pkg
// Brief  : Shared types, defaults and round-robin pick helper for the
//          serial shift scheduler.
// Rev    : 1.0 - initial release
// ============================================================================
package ser_pkg;

    localparam int c_NUM_REQ_DEF = 4;
    localparam int c_WIDTH_DEF   = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Scans from the highest offset down so the nearest set request after ptr wins.
    function automatic int rr_pick(input logic [31:0] req, input int ptr, input int n);
        logic [4:0] w_sel;
        rr_pick = 0;
        for (int i = n - 1; i >= 0; i--) begin
            w_sel = 5'((ptr + i) % n);
            if (req[w_sel]) begin
                rr_pick = {27'd0, w_sel};
            end
        end
    endfunction

endpackage
`default_nettype wire

// File: rtl/serial_shift_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module : serial_shift_scheduler_if
// Brief  : Requester bus and serial output bundle of the shift scheduler.
// Rev    : 1.0 - initial release
// ============================================================================
interface serial_shift_scheduler_if
    import ser_pkg::*;
#(
    parameter int NUM_REQ = c_NUM_REQ_DEF,
    parameter int WIDTH   = c_WIDTH_DEF
);
    localparam int IW = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]       req_i;
    logic [NUM_REQ*WIDTH-1:0] data_i;
    logic [NUM_REQ-1:0]       gnt_o;
    logic [NUM_REQ-1:0]       ack_o;
    logic                     ser_bit_o;
    logic                     ser_valid_o;
    logic                     ser_last_o;
    logic                     busy_o;
    logic [IW-1:0]            owner_o;

    modport master (
        output req_i, data_i,
        input  gnt_o, ack_o, ser_bit_o, ser_valid_o, ser_last_o, busy_o, owner_o
    );

    modport slave (
        input  req_i, data_i,
        output gnt_o, ack_o, ser_bit_o, ser_valid_o, ser_last_o, busy_o, owner_o
    );

endinterface
`default_nettype wire

// File: rtl/serial_shift_scheduler_arb.sv
`default_nettype none
// ============================================================================
// Module : rr_arbiter
// Brief  : Combinational round-robin pick starting at i_ptr.
// Rev    : 1.0 - initial release
// ============================================================================
module rr_arbiter
    import ser_pkg::*;
#(
    parameter int NUM_REQ = c_NUM_REQ_DEF,
    parameter int IW      = $clog2(NUM_REQ)
) (
    input  wire logic [NUM_REQ-1:0] i_req,
    input  wire logic [IW-1:0]      i_ptr,
    output logic      [NUM_REQ-1:0] o_gnt,
    output logic      [IW-1:0]      o_idx
);

    int w_win;

    always_comb begin
        w_win = rr_pick(32'(i_req), int'(i_ptr), NUM_REQ);
        o_idx = IW'(w_win);
        o_gnt = '0;
        if (|i_req) begin
            o_gnt[o_idx] = 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/serial_shift_scheduler.sv
`default_nettype none
// ============================================================================
// Module : serial_shift_scheduler
// Brief  : Round-robin shares one LSB-first serializer among NUM_REQ requesters.
// Rev    : 1.0 - initial release
// ============================================================================
module serial_shift_scheduler
    import ser_pkg::*;
#(
    parameter int NUM_REQ    = c_NUM_REQ_DEF,
    parameter int WIDTH      = c_WIDTH_DEF,
    parameter int EARLY_STOP = 0
) (
    input wire logic                 Clk,
    input wire logic                 Rst_n,
    serial_shift_scheduler_if.slave  bus
);

    localparam int IW = $clog2(NUM_REQ);
    localparam int CW = $clog2(WIDTH) + 1;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [WIDTH-1:0]   r_shreg;
    logic [CW-1:0]      r_cnt;
    logic [IW-1:0]      r_owner;
    logic [IW-1:0]      r_rr_ptr;
    logic [IW-1:0]      w_ptr_nxt;
    logic [NUM_REQ-1:0] w_arb_gnt;
    logic [IW-1:0]      w_win_idx;
    logic [NUM_REQ-1:0] w_owner_oh;
    logic               w_any;
    logic               w_last;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IW      (IW)
    ) u_arb (
        .i_req (bus.req_i),
        .i_ptr (r_rr_ptr),
        .o_gnt (w_arb_gnt),
        .o_idx (w_win_idx)
    );

    assign w_any      = |w_arb_gnt;
    assign w_ptr_nxt  = (r_owner == IW'(NUM_REQ - 1)) ? '0 : r_owner + 1'b1;
    assign w_owner_oh = NUM_REQ'(1) << r_owner;
    // Early stop looks at what remains after the bit currently on the line.
    assign w_last     = (r_cnt == CW'(WIDTH - 1)) ||
                        ((EARLY_STOP != 0) && (r_shreg[WIDTH-1:1] == '0));

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_any)  w_state_nxt = SHIFT;
            SHIFT:   if (w_last) w_state_nxt = DONE;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            r_shreg  <= '0;
            r_cnt    <= '0;
            r_owner  <= '0;
            r_rr_ptr <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_shreg <= bus.data_i[w_win_idx*WIDTH +: WIDTH];
                        r_owner <= w_win_idx;
                        r_cnt   <= '0;
                    end
                end
                SHIFT: begin
                    r_shreg <= r_shreg >> 1;
                    r_cnt   <= r_cnt + 1'b1;
                end
                DONE:    r_rr_ptr <= w_ptr_nxt;
                default: ;
            endcase
        end
    end

    assign bus.gnt_o       = (r_state != IDLE) ? w_owner_oh : '0;
    assign bus.ack_o       = (r_state == DONE) ? w_owner_oh : '0;
    assign bus.ser_bit_o   = r_shreg[0];
    assign bus.ser_valid_o = (r_state == SHIFT);
    assign bus.ser_last_o  = (r_state == SHIFT) && w_last;
    assign bus.busy_o      = (r_state != IDLE);
    assign bus.owner_o     = r_owner;

endmodule
`default_nettype wire

// File: tb/tb_serial_shift_scheduler.sv
`default_nettype none
// ============================================================================
// Module : tb_serial_shift_scheduler
// Brief  : Directed self-checking bench; dut0 normal, dut1 with early stop.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_serial_shift_scheduler;

    logic Clk;
    logic Rst_n;
    logic r_sel;
    int   total;
    int   bad;
    int   r_cyc;

    serial_shift_scheduler_if #(.NUM_REQ(4), .WIDTH(8)) if0 ();
    serial_shift_scheduler_if #(.NUM_REQ(4), .WIDTH(8)) if1 ();

    serial_shift_scheduler #(.NUM_REQ(4), .WIDTH(8), .EARLY_STOP(0)) u_dut0 (
        .Clk   (Clk),
        .Rst_n (Rst_n),
        .bus   (if0)
    );

    serial_shift_scheduler #(.NUM_REQ(4), .WIDTH(8), .EARLY_STOP(1)) u_dut1 (
        .Clk   (Clk),
        .Rst_n (Rst_n),
        .bus   (if1)
    );

    logic [3:0] w_gnt, w_ack;
    logic [1:0] w_owner;
    logic       w_bit, w_valid, w_last, w_busy;

    assign w_gnt   = r_sel ? if1.gnt_o       : if0.gnt_o;
    assign w_ack   = r_sel ? if1.ack_o       : if0.ack_o;
    assign w_owner = r_sel ? if1.owner_o     : if0.owner_o;
    assign w_bit   = r_sel ? if1.ser_bit_o   : if0.ser_bit_o;
    assign w_valid = r_sel ? if1.ser_valid_o : if0.ser_valid_o;
    assign w_last  = r_sel ? if1.ser_last_o  : if0.ser_last_o;
    assign w_busy  = r_sel ? if1.busy_o      : if0.busy_o;

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    initial r_cyc = 0;
    always @(posedge Clk) r_cyc <= r_cyc + 1;

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input logic [3:0] r);
        if (r_sel) if1.req_i = r;
        else       if0.req_i = r;
    endtask

    task automatic set_data(input int k, input logic [7:0] w);
        if (r_sel) if1.data_i[k*8 +: 8] = w;
        else       if0.data_i[k*8 +: 8] = w;
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_gnt"},   w_gnt,   0);
        chk({tag, "_ack"},   w_ack,   0);
        chk({tag, "_owner"}, w_owner, 0);
        chk({tag, "_bit"},   w_bit,   0);
        chk({tag, "_valid"}, w_valid, 0);
        chk({tag, "_last"},  w_last,  0);
        chk({tag, "_busy"},  w_busy,  0);
    endtask

    // Entered in the first SHIFT cycle; leaves in the IDLE cycle after DONE.
    task automatic frame(input int own, input logic [7:0] w, input int nbits,
                         input logic [3:0] req_done, input int chg_at);
        logic [3:0] e;
        e = 4'b0001 << own;
        chk("frame_gnt", w_gnt, e);
        chk("frame_owner", w_owner, own);
        for (int i = 0; i < nbits; i++) begin
            if (i == chg_at) begin
                set_req(4'b0000);
                set_data(own, ~w);
            end
            chk("bit", w_bit, w[i]);
            chk("valid", w_valid, 1);
            chk("last", w_last, (i == nbits - 1));
            step();
        end
        chk("done_ack", w_ack, e);
        chk("done_valid", w_valid, 0);
        chk("done_gnt", w_gnt, e);
        set_req(req_done);
        step();
        chk("idle_busy", w_busy, 0);
        chk("idle_ack", w_ack, 0);
    endtask

    initial begin
        logic [7:0] words [4];
        int         t0;
        words = '{8'h12, 8'h34, 8'h56, 8'h78};
        total = 0;
        bad   = 0;
        r_sel = 1'b0;
        Rst_n = 1'b0;
        if0.req_i = '0; if0.data_i = '0;
        if1.req_i = '0; if1.data_i = '0;
        step();
        step();
        chk_quiet("reset0");
        r_sel = 1'b1;
        chk_quiet("reset1");
        r_sel = 1'b0;

        // 1: single requester, A5 LSB first
        Rst_n = 1'b1;
        set_data(1, 8'hA5);
        set_req(4'b0010);
        step();
        frame(1, 8'hA5, 8, 4'b0000, -1);
        chk("t1_owner_hold", w_owner, 1);

        // 2: all requesting, fair rotation from a fresh pointer
        Rst_n = 1'b0;
        step();
        Rst_n = 1'b1;
        for (int k = 0; k < 4; k++) set_data(k, words[k]);
        set_req(4'b1111);
        step();
        for (int k = 0; k < 5; k++) begin
            t0 = r_cyc;
            frame(k % 4, words[k % 4], 8, (k == 4) ? 4'b0000 : 4'b1111, -1);
            if (k < 4) begin
                step();
                chk("t2_period", r_cyc - t0, 10);
            end
        end

        // 3: early stop on dut1
        r_sel = 1'b1;
        set_data(0, 8'h0A);
        set_req(4'b0001);
        step();
        frame(0, 8'h0A, 4, 4'b0000, -1);
        set_data(0, 8'h00);
        set_req(4'b0001);
        step();
        frame(0, 8'h00, 1, 4'b0000, -1);
        r_sel = 1'b0;

        // 4: reset mid-frame clears pointer and drops the frame
        set_data(2, 8'hC3);
        set_data(3, 8'h99);
        set_req(4'b0100);
        step();
        frame(2, 8'hC3, 8, 4'b0000, -1);
        set_req(4'b0100);
        step();
        chk("t4_owner", w_owner, 2);
        for (int i = 0; i < 3; i++) begin
            chk("t4_bit", w_bit, (8'hC3 >> i) & 8'h01);
            step();
        end
        Rst_n = 1'b0;
        set_req(4'b1100);
        step();
        chk_quiet("t4_abort");
        Rst_n = 1'b1;
        step();
        frame(2, 8'hC3, 8, 4'b0000, -1);

        // 5: data change and req drop mid-frame are ignored
        set_data(1, 8'h5C);
        set_req(4'b0010);
        step();
        frame(1, 8'h5C, 8, 4'b0000, 3);

        // 6: req2 raised during req0's DONE wins next, then req0
        set_data(0, 8'h81);
        set_data(2, 8'h3C);
        set_req(4'b0001);
        step();
        frame(0, 8'h81, 8, 4'b0101, -1);
        step();
        frame(2, 8'h3C, 8, 4'b0001, -1);
        step();
        frame(0, 8'h81, 8, 4'b0000, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
